// File: rtl/fx_pkg.sv
// fx_pkg: types and constants shared by the FX chain output stage.
package fx_pkg;

  // Default channel sample width of the FX chain
  localparam int FX_DATA_W = 16;

  // Stereo frame as carried on the FX audio buses: [0]=left, [1]=right
  typedef logic [1:0][FX_DATA_W-1:0] stereo_t;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_t;

  // Channel indices into a stereo frame
  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to the I2S bit clock. It produces a fall
// strobe on the clk cycle where BCLK goes low, which is when the serializer
// updates LRCLK and SDATA. While disabled the divider is frozen and BCLK is
// held low. force_fall restarts the divider from zero with BCLK low, so the
// first rise comes CLK_DIV clk cycles after the idle exit.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic force_fall,
  output logic bclk,
  output logic fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic tick;
  logic rise;

  assign tick = en && (div == DIV_LAST);
  assign fall = tick && bclk;
  assign rise = tick && !bclk;

  // Divider and BCLK register: toggle BCLK every CLK_DIV enabled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (force_fall) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (fall) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (rise) begin
      div  <= '0;
      bclk <= 1'b1;
    end else if (en) begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/fx_i2s_tx.sv
// fx_i2s_tx: stereo Philips I2S transmitter at the end of the FX chain.
// A frame arrives through a valid/ready handshake into a holding register,
// is moved to a shadow register at the start of each left slot and shifted
// out MSB first one BCLK after each LRCLK edge.
// Build option FX_I2S_TX_MUTE_ON_UNDERRUN_EN: when defined, an underrun
// loads a silent frame; otherwise the previous frame is repeated.
module fx_i2s_tx
  import fx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   underrun
);

  localparam int BIT_W = $clog2(SLOT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

  i2s_state_t state;
  logic [BIT_W-1:0] bit_idx;
  logic hold_full;
  logic [1:0][DATA_W-1:0] hold_data;
  logic [1:0][DATA_W-1:0] shadow;
  logic [1:0][DATA_W-1:0] next_shadow;
  logic [DATA_W-1:0] shreg;
  logic bclk_fall;
  logic force_fall;
  logic fall_ev;
  logic en;
  logic accept;
  logic slot_end;
  logic frame_load;

  assign in_ready   = ~hold_full;
  assign accept     = in_valid && ~hold_full;
  assign en         = (state != ST_IDLE);
  assign force_fall = (state == ST_IDLE) && hold_full;
  assign fall_ev    = bclk_fall || force_fall;
  assign slot_end   = (bit_idx == BIT_LAST);
  assign frame_load = force_fall || (bclk_fall && (state == ST_RIGHT) && slot_end);

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .force_fall (force_fall),
    .bclk       (i2s_bclk),
    .fall       (bclk_fall)
  );

  // Frame chosen at a frame load: the waiting frame, or the underrun fallback
  always_comb begin
    next_shadow = shadow;
    if (hold_full) begin
      next_shadow = hold_data;
    end else begin
`ifdef FX_I2S_TX_MUTE_ON_UNDERRUN_EN
      next_shadow = '0;
`else
      next_shadow = shadow;
`endif
    end
  end

  // Holding register: filled by the handshake, freed by a frame load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (frame_load && hold_full) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= audio_in;
    end
  end

  // Slot sequencer and serializer, advanced on every BCLK fall event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      shadow    <= '0;
      shreg     <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall_ev) begin
        if (frame_load) begin
          state     <= ST_LEFT;
          bit_idx   <= '0;
          i2s_lrclk <= 1'b0;
          i2s_sdata <= 1'b0;
          shadow    <= next_shadow;
          shreg     <= next_shadow[CH_LEFT];
          underrun  <= ~hold_full;
        end else if (slot_end) begin
          state     <= ST_RIGHT;
          bit_idx   <= '0;
          i2s_lrclk <= 1'b1;
          i2s_sdata <= 1'b0;
          shreg     <= shadow[CH_RIGHT];
        end else begin
          bit_idx   <= bit_idx + BIT_W'(1);
          i2s_sdata <= shreg[DATA_W-1];
          shreg     <= {shreg[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule
